// File: rtl/ram_stream_reader.sv
// Streams the character buffer RAM out over a valid/ready byte link, row-major.
// Build option: define DUMP_CRLF_EN to terminate every row with CR LF.
module ram_stream_reader #(
    parameter int ROW_W = 5,
    parameter int COL_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] r_row,
    output logic [COL_W-1:0] r_col,
    input  logic [7:0]       rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_SEND,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic [COL_W-1:0] COL_MAX = '1;

    state_t state;
    logic   row_last;
    logic   col_last;
    logic   hs;

    assign row_last = (r_row == ROW_MAX);
    assign col_last = (r_col == COL_MAX);
    assign hs       = tx_valid & tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_col <= '0;
                        busy  <= 1'b1;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Empty cells are shown as spaces on the terminal
                    tx_data  <= (rdata == 8'h00) ? 8'h20 : rdata;
                    tx_valid <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        if (!col_last) begin
                            r_col    <= r_col + 1'b1;
                            tx_valid <= 1'b0;
                            state    <= S_ADDR;
                        end else begin
`ifdef DUMP_CRLF_EN
                            tx_data <= 8'h0D;
                            state   <= S_CR;
`else
                            tx_valid <= 1'b0;
                            if (!row_last) begin
                                r_row <= r_row + 1'b1;
                                r_col <= '0;
                                state <= S_ADDR;
                            end else begin
                                tx_data <= 8'h00;
                                r_row   <= '0;
                                r_col   <= '0;
                                done    <= 1'b1;
                                state   <= S_DONE;
                            end
`endif
                        end
                    end
                end
                S_CR: begin
                    if (hs) begin
                        tx_data <= 8'h0A;
                        state   <= S_LF;
                    end
                end
                S_LF: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        if (!row_last) begin
                            r_row <= r_row + 1'b1;
                            r_col <= '0;
                            state <= S_ADDR;
                        end else begin
                            tx_data <= 8'h00;
                            r_row   <= '0;
                            r_col   <= '0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, random backpressure, stream scoreboard.
// Follows the DUMP_CRLF_EN build option of the design.
module tb_ram_stream_reader;

`ifdef DUMP_CRLF_EN
    localparam int CRLF = 1;
`else
    localparam int CRLF = 0;
`endif
    localparam int ROWS = 32;
    localparam int COLS = 4;
    localparam int STRIDE = COLS + 2 * CRLF;
    localparam int FULL_LAT = ROWS * COLS * 3 + ROWS * 2 * CRLF;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] r_row;
    logic [1:0] r_col;
    logic [7:0] rdata = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    ram_stream_reader #(.ROW_W(5), .COL_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .r_row    (r_row),
        .r_col    (r_col),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:ROWS-1][0:COLS-1];

    always @(posedge clk) rdata <= mem[r_row][r_col];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from DUT updates
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int  ncnt = 0;
    int  done_cnt = 0;
    int  done_at = 0;
    bit  prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        ncnt++;
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (done) begin
                done_cnt++;
                done_at = ncnt;
            end
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0h expected v=1 d=%0h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    int ready_pct = 100;

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2 tx_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Reference stream: what a terminal should see, from the buffer contents
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(mem[r][c] == 8'h00 ? 8'h20 : mem[r][c]);
            if (CRLF != 0) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    task automatic preload(input int kind);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (kind == 1) begin
                    mem[r][c] = ($urandom_range(9) == 0) ? 8'h00
                                : 8'($urandom_range(255));
                end else begin
                    mem[r][c] = 8'(8'h41 + ((4 * r + c) % 26));
                end
            end
        if (kind == 2) begin
            mem[3][2] = 8'h00;
            mem[5][1] = 8'h7E;
        end
    endtask

    int s_idx = 0;

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        s_idx = ncnt + 1;
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt > base) break;
        end
        if (k == budget) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done expected done within %0d", budget);
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    typedef struct {
        int kind;
        int pct;
        bit chk_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        int idx;
        bit hit;
        vecs[0] = '{0, 100, 1'b1};
        vecs[1] = '{2, 100, 1'b1};
        vecs[2] = '{0, 40, 1'b0};
        vecs[3] = '{1, 40, 1'b0};
        vecs[4] = '{1, 75, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        preload(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_row", r_row, 0);
        chk("rst_col", r_col, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            ready_pct = vecs[v].pct;
            preload(vecs[v].kind);
            build_expected();
            got_q.delete();
            base = done_cnt;
            pulse_start();
            @(negedge clk);
            chk($sformatf("v%0d_busy_run", v), busy, 1);
            wait_done(4000, base);
            if (vecs[v].chk_lat)
                chk($sformatf("v%0d_latency", v), done_at - s_idx, FULL_LAT);
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_done_once", v), done_cnt - base, 1);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_valid_end", v), tx_valid, 0);
            chk($sformatf("v%0d_data_end", v), tx_data, 0);
            cmp_stream($sformatf("v%0d", v));
            if (vecs[v].kind == 2 && got_q.size() == exp_q.size()) begin
                chk("empty_cell_space", got_q[3 * STRIDE + 2], 8'h20);
                chk("tilde_passthru", got_q[5 * STRIDE + 1], 8'h7E);
            end
        end

        // Second start mid-dump must be ignored
        ready_pct = 100;
        preload(0);
        build_expected();
        got_q.delete();
        base = done_cnt;
        pulse_start();
        repeat (48) @(negedge clk);
        #3 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(4000, base);
        chk("restart_latency", done_at - s_idx, FULL_LAT);
        repeat (20) @(negedge clk);
        chk("restart_done_once", done_cnt - base, 1);
        chk("restart_busy_end", busy, 0);
        cmp_stream("restart");

        // Reset while a byte at row 10 is offered
        preload(2);
        build_expected();
        base = done_cnt;
        pulse_start();
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            hit = (r_row == 5'd10) && tx_valid;
        end
        chk("reached_row10", hit, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_row", r_row, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - base, 0);
        chk("mid_rst_idle", busy, 0);
        got_q.delete();
        idx = done_cnt;
        pulse_start();
        wait_done(4000, idx);
        chk("after_rst_latency", done_at - s_idx, FULL_LAT);
        repeat (4) @(negedge clk);
        cmp_stream("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
